// File: rtl/mem_access_pkg.sv
// Shared pipeline definitions: bus widths, ALU op codes (including load/store)
// and byte-lane select constants used by the memory access stage.
package mem_access_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: decodes load/store ops, aligns the address, builds
// byte selects, replicates store data and extends load data.
// Optional misalignment fault reporting is enabled with MEM_ALIGN_CHECK_EN.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]        aluop_i,
    input  logic [RegBus-1:0] addr_i,
    input  logic [RegBus-1:0] store_data_i,
    input  logic [RegBus-1:0] load_data_i,
    output logic              is_mem_o,
    output logic              is_load_o,
    output logic              align_fault_o,
    output logic [RegBus-1:0] addr_o,
    output logic [3:0]        sel_o,
    output logic [RegBus-1:0] store_lanes_o,
    output logic [RegBus-1:0] load_result_o
);

    mem_size_e         size;
    logic              signed_ld;
    logic [RegBus-1:0] shifted;

    always_comb begin
        is_mem_o  = 1'b1;
        is_load_o = 1'b0;
        signed_ld = 1'b0;
        size      = SZ_WORD;
        case (aluop_i)
            EXE_LB_OP:  begin is_load_o = 1'b1; signed_ld = 1'b1; size = SZ_BYTE; end
            EXE_LBU_OP: begin is_load_o = 1'b1; size = SZ_BYTE; end
            EXE_LH_OP:  begin is_load_o = 1'b1; signed_ld = 1'b1; size = SZ_HALF; end
            EXE_LHU_OP: begin is_load_o = 1'b1; size = SZ_HALF; end
            EXE_LW_OP:  is_load_o = 1'b1;
            EXE_SB_OP:  size = SZ_BYTE;
            EXE_SH_OP:  size = SZ_HALF;
            EXE_SW_OP:  size = SZ_WORD;
            default:    is_mem_o = 1'b0;
        endcase
    end

    // Lanes are picked from the aligned address, so a forced-aligned access
    // behaves exactly like the naturally aligned one.
    always_comb begin
        addr_o        = addr_i;
        sel_o         = SEL_WORD;
        store_lanes_o = store_data_i;
        case (size)
            SZ_BYTE: begin
                sel_o         = SEL_BYTE << addr_i[1:0];
                store_lanes_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                addr_o[0]     = 1'b0;
                sel_o         = SEL_HALF << {addr_i[1], 1'b0};
                store_lanes_o = {2{store_data_i[15:0]}};
            end
            default: begin
                addr_o[1:0]   = 2'b00;
            end
        endcase
    end

    always_comb begin
        shifted = load_data_i >> {addr_o[1:0], 3'b000};
        case (size)
            SZ_BYTE: load_result_o = {{24{signed_ld & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_result_o = {{16{signed_ld & shifted[15]}}, shifted[15:0]};
            default: load_result_o = shifted;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault_o = is_mem_o &
                           ((size == SZ_HALF) ? addr_i[0] :
                            (size == SZ_WORD) ? |addr_i[1:0] : 1'b0);
`else
    assign align_fault_o = 1'b0;
`endif

endmodule

// File: rtl/mem_access.sv
// Memory access pipeline stage: issues one data-bus transaction per load/store,
// stalls upstream until ack or timeout, and registers the write-back result.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [7:0]            aluop_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [RegBus-1:0]     store_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [RegBus-1:0]     mem_addr_o,
    output logic [3:0]            mem_sel_o,
    output logic [RegBus-1:0]     mem_data_o,
    input  logic                  mem_ack_i,
    input  logic [RegBus-1:0]     mem_data_i,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  bus_err_o
);

    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, BUS} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [RegAddrBus-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [RegBus-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  req, stall;

    logic                  is_mem, is_load, align_fault;
    logic [RegBus-1:0]     aligned_addr, store_lanes, load_result;
    logic [3:0]            sel;

    mem_align u_align (
        .aluop_i       (aluop_i),
        .addr_i        (wdata_i),
        .store_data_i  (store_data_i),
        .load_data_i   (mem_data_i),
        .is_mem_o      (is_mem),
        .is_load_o     (is_load),
        .align_fault_o (align_fault),
        .addr_o        (aligned_addr),
        .sel_o         (sel),
        .store_lanes_o (store_lanes),
        .load_result_o (load_result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        err_d   = 1'b0;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wdata_d = wdata_i;
                    if (!is_mem) begin
                        wreg_d = wreg_i;
                    end else if (align_fault) begin
                        err_d = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (mem_ack_i) begin
                            wreg_d  = is_load & wreg_i;
                            wdata_d = is_load ? load_result : wdata_i;
                        end else begin
                            // No result yet: suppress the write-back until ack.
                            valid_d = 1'b0;
                            stall   = 1'b1;
                            state_d = BUS;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
            end
            BUS: begin
                if (cnt_q == CntMax) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wdata_d = wdata_i;
                    err_d   = 1'b1;
                end else begin
                    req = 1'b1;
                    if (mem_ack_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = is_load & wreg_i;
                        wdata_d = is_load ? load_result : wdata_i;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs depend on live inputs, so reset must gate them directly.
    assign mem_req_o  = req & ~rst;
    assign stallreq_o = stall & ~rst;
    assign mem_we_o   = mem_req_o & ~is_load;
    assign mem_addr_o = mem_req_o ? aligned_addr : '0;
    assign mem_sel_o  = mem_req_o ? sel : 4'b0000;
    assign mem_data_o = mem_we_o ? store_lanes : '0;

    assign valid_o   = valid_q;
    assign wd_o      = wd_q;
    assign wreg_o    = wreg_q;
    assign wdata_o   = wdata_q;
    assign bus_err_o = err_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack_i before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 valid_i  in  1  EX result present this cycle.
REQ-005 aluop_i  in  8  operation; load/store codes LB, LBU, LH, LHU, LW, SB, SH, SW; any other code is non-memory.
REQ-006 wd_i / wreg_i / wdata_i  in  5/1/32  EX destination, write enable and result; wdata_i is the effective address for memory ops.
REQ-007 store_data_i  in  32  store operand (reg2).
REQ-008 mem_req_o / mem_we_o / mem_addr_o / mem_sel_o / mem_data_o  out  1/1/32/4/32  data-bus request, write, address, byte lanes, write data.
REQ-009 mem_ack_i / mem_data_i  in  1/32  bus completion and read data (valid with ack).
REQ-010 stallreq_o  out  1  combinational upstream stall request.
REQ-011 valid_o / wd_o / wreg_o / wdata_o  out  1/5/1/32  registered write-back result.
REQ-012 bus_err_o  out  1  one-cycle pulse on timeout or alignment fault.

Function
REQ-013 States SHALL be IDLE, BUS, WAIT_ACK-free; exactly IDLE and BUS.
REQ-014 IDLE, valid_i, non-memory op: outputs SHALL register wd_i/wreg_i/wdata_i next edge, valid_o=1, no stall, latency 1.
REQ-015 IDLE, valid_i, memory op: mem_req_o SHALL assert combinationally that cycle, stallreq_o=1, next state BUS unless mem_ack_i is already 1.
REQ-016 BUS: mem_req_o, address, sel, we, data SHALL stay stable; stallreq_o=1 while mem_ack_i=0; upstream inputs held stable by stall.
REQ-017 Ack cycle: stallreq_o=0, result registered on that edge, state IDLE; back-to-back memory ops allowed with no bubble.
REQ-018 Little-endian lanes: byte sel=1<<addr[1:0], half sel=3<<addr[1:0], word sel=4'hF; store data replicated across lanes.
REQ-019 Loads: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW passes mem_data_i; wreg_o=wreg_i.
REQ-020 Stores: wreg_o=0, valid_o=1.
REQ-021 Timeout: cycle counter in BUS reaching TIMEOUT_CYCLES SHALL drop mem_req_o, pulse bus_err_o, return IDLE, emit valid_o=1, wreg_o=0.
REQ-022 valid_i=0 in IDLE: valid_o=0, wreg_o=0, no bus activity.

Reset
REQ-023 rst=1 SHALL force IDLE, counter 0, all outputs 0, mem_req_o=0, immediately and regardless of clock.
REQ-024 Reset mid-BUS SHALL abandon the transaction; a late mem_ack_i after reset SHALL be ignored.

Configuration
REQ-025 Macro MEM_ALIGN_CHECK_EN defined: misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no bus request, pulse bus_err_o, valid_o=1, wreg_o=0, latency 1.
REQ-026 Macro undefined: halfword ops SHALL clear addr[0], word ops SHALL clear addr[1:0] on mem_addr_o and lane selection; no fault.

Structure
REQ-027 Memory aluop codes, lane-select constants and RegBus/RegAddrBus widths SHALL live in the shared package with existing op codes; state enum local.
REQ-028 One combinational sub-module mem_align SHALL produce sel, store lanes and load extension.

Verification
REQ-029 OR op, valid_i=1, wd_i=5, wdata_i=32'hF0F0 -> next cycle valid_o=1, wd_o=5, wdata_o=32'hF0F0, no mem_req_o.
REQ-030 LB addr 32'h1003, ack after 3 cycles with data 32'h80000000 -> stallreq_o high 3 cycles, wdata_o=32'hFFFFFF80.
REQ-031 SH addr 32'h2002, data 32'h1234 -> mem_sel_o=4'b1100, mem_data_o=32'h12341234, mem_we_o=1, wreg_o=0.
REQ-032 LW, ack never, TIMEOUT_CYCLES=4 -> mem_req_o drops after 4 cycles, bus_err_o pulse, wreg_o=0.
REQ-033 LW addr 32'h1001 with MEM_ALIGN_CHECK_EN -> no mem_req_o, bus_err_o=1; without macro -> mem_addr_o=32'h1000.
REQ-034 rst asserted during BUS -> mem_req_o=0 without clock edge; late ack produces no valid_o.
